// File: rtl/hazard_pkg.sv
// Shared types for the ID->EX hazard/forwarding controller: EX operand mux
// encodings and the stall FSM state set.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        DEP_STALL
    } hz_state_t;

    // Youngest producer wins; a load still in EX has no data to forward yet.
    function automatic fwd_sel_t pick_fwd(input logic fwd_en,
                                          input logic m_ex,
                                          input logic ex_is_load,
                                          input logic m_mem);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (fwd_en) begin
            if (m_ex && !ex_is_load) begin
                sel = FWD_EXMEM;
            end else if (m_mem) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// Per-source comparator: matches one ID source register against the EX, MEM
// and WB destinations and proposes that source's forward select.
module hazard_src_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  forward_en,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_valid,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_regwrite,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_regwrite,
    output logic                  match_ex,
    output logic                  match_mem,
    output logic                  match_wb,
    output fwd_sel_t              next_sel
);

    always_comb begin
        match_ex  = src_valid && id_ex_regwrite  && (id_ex_rd  != '0) && (src_addr == id_ex_rd);
        match_mem = src_valid && ex_mem_regwrite && (ex_mem_rd != '0) && (src_addr == ex_mem_rd);
        match_wb  = src_valid && mem_wb_regwrite && (mem_wb_rd != '0) && (src_addr == mem_wb_rd);
        next_sel  = pick_fwd(forward_en, match_ex, id_ex_memread, match_mem);
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ID->EX hazard unit: registered per-source forward selects plus a load-use /
// RAW-dependency stall FSM with a saturating stall-cycle counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter bit          RF_WR_THROUGH  = 1'b1,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          forward_en,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic [REG_ADDR_W-1:0]         id_ex_rd,
    input  logic                          id_ex_regwrite,
    input  logic                          id_ex_memread,
    input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
    input  logic                          ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
    input  logic                          mem_wb_regwrite,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          id_ex_bubble,
    output logic                          stall_start,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    localparam int unsigned LU_CNT_W = (LOAD_USE_STALL > 2) ? $clog2(LOAD_USE_STALL) : 1;
    localparam logic [LU_CNT_W-1:0] LU_CNT_INIT =
        (LOAD_USE_STALL >= 2) ? LU_CNT_W'(LOAD_USE_STALL - 2) : '0;

    logic [NUM_SRC-1:0]     match_ex;
    logic [NUM_SRC-1:0]     match_mem;
    logic [NUM_SRC-1:0]     match_wb;
    logic [2*NUM_SRC-1:0]   next_sel;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_cmp #(
            .REG_ADDR_W(REG_ADDR_W)
        ) u_cmp (
            .forward_en     (forward_en),
            .src_addr       (id_src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
            .src_valid      (id_src_valid[g]),
            .id_ex_rd       (id_ex_rd),
            .id_ex_regwrite (id_ex_regwrite),
            .id_ex_memread  (id_ex_memread),
            .ex_mem_rd      (ex_mem_rd),
            .ex_mem_regwrite(ex_mem_regwrite),
            .mem_wb_rd      (mem_wb_rd),
            .mem_wb_regwrite(mem_wb_regwrite),
            .match_ex       (match_ex[g]),
            .match_mem      (match_mem[g]),
            .match_wb       (match_wb[g]),
            .next_sel       (next_sel[2*g +: 2])
        );
    end

    logic lu_haz;
    logic dep_haz;

    always_comb begin
        lu_haz  = forward_en && id_ex_memread && (|match_ex);
        dep_haz = !forward_en && (|(match_ex | match_mem | (RF_WR_THROUGH ? '0 : match_wb)));
    end

    hz_state_t            state_q, state_d;
    logic [LU_CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic                 stall_raw;
    logic                 start_raw;

    always_comb begin
        state_d   = state_q;
        lu_cnt_d  = lu_cnt_q;
        stall_raw = 1'b0;
        start_raw = 1'b0;
        case (state_q)
            RUN: begin
                if (lu_haz) begin
                    stall_raw = 1'b1;
                    start_raw = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        state_d  = LU_STALL;
                        lu_cnt_d = LU_CNT_INIT;
                    end
                end else if (dep_haz) begin
                    stall_raw = 1'b1;
                    start_raw = 1'b1;
                    state_d   = DEP_STALL;
                end
            end
            LU_STALL: begin
                stall_raw = 1'b1;
                if (lu_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
                end
            end
            DEP_STALL: begin
                // Release cycle itself is not stalled; a new hazard is only seen back in RUN.
                if (dep_haz) begin
                    stall_raw = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are held low for the whole time reset is asserted, not just after the edge.
    always_comb begin
        stall        = stall_raw && rst_n;
        id_ex_bubble = stall;
        stall_start  = start_raw && rst_n;
    end

    logic [2*NUM_SRC-1:0]   fwd_sel_q, fwd_sel_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        fwd_sel_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fwd_sel_d[2*i +: 2] = stall ? 2'(FWD_RF) : next_sel[2*i +: 2];
        end
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            lu_cnt_q       <= '0;
            fwd_sel_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            lu_cnt_q       <= lu_cnt_d;
            fwd_sel_q      <= fwd_sel_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign fwd_sel      = fwd_sel_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: default instance plus variants with
// a 3-bubble load-use stall and a 4-bit stall counter, all on shared inputs.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        rst_n;
    logic        forward_en;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_valid;
    logic [4:0]  id_ex_rd;
    logic        id_ex_regwrite;
    logic        id_ex_memread;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;

    logic [3:0]  fwd_sel,   fwd_sel_l3,   fwd_sel_c4;
    logic        stall,     stall_l3,     stall_c4;
    logic        bubble,    bubble_l3,    bubble_c4;
    logic        start,     start_l3,     start_c4;
    logic [15:0] cyc;
    logic [15:0] cyc_l3;
    logic [3:0]  cyc_c4;

    int errors = 0;
    int checks = 0;

    hazard_forward_ctrl dut (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .fwd_sel(fwd_sel), .stall(stall), .id_ex_bubble(bubble),
        .stall_start(start), .stall_cycles(cyc)
    );

    hazard_forward_ctrl #(.LOAD_USE_STALL(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .fwd_sel(fwd_sel_l3), .stall(stall_l3), .id_ex_bubble(bubble_l3),
        .stall_start(start_l3), .stall_cycles(cyc_l3)
    );

    hazard_forward_ctrl #(.STALL_CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .fwd_sel(fwd_sel_c4), .stall(stall_c4), .id_ex_bubble(bubble_c4),
        .stall_start(start_c4), .stall_cycles(cyc_c4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        forward_en      = 1'b1;
        id_src_addr     = '0;
        id_src_valid    = '0;
        id_ex_rd        = '0;
        id_ex_regwrite  = 1'b0;
        id_ex_memread   = 1'b0;
        ex_mem_rd       = '0;
        ex_mem_regwrite = 1'b0;
        mem_wb_rd       = '0;
        mem_wb_regwrite = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        forward_en = 1'b0;
        id_src_addr = 10'd6;
        id_src_valid = 2'b01;
        id_ex_rd = 5'd6;
        id_ex_regwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got stall=%b bubble=%b start=%b exp 0 0 0", stall, bubble, start);
        end
        checks++;
        if (fwd_sel !== 4'b0000 || cyc !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs got fwd_sel=%b cyc=%0d exp 0000 0", fwd_sel, cyc);
        end
    endtask

    task automatic test_fwd_exmem();
        do_reset();
        id_src_addr = {5'd0, 5'd3};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd3;
        id_ex_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL t1_no_stall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0010) begin
            errors++;
            $display("FAIL t1_fwd_exmem got=%b exp=0010", fwd_sel);
        end
        id_ex_regwrite = 1'b0;
        ex_mem_rd = 5'd3;
        ex_mem_regwrite = 1'b1;
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            errors++;
            $display("FAIL t1_fwd_memwb got=%b exp=0001", fwd_sel);
        end
    endtask

    task automatic test_priority();
        do_reset();
        id_src_addr = {5'd5, 5'd0};
        id_src_valid = 2'b10;
        id_ex_rd = 5'd5;
        id_ex_regwrite = 1'b1;
        ex_mem_rd = 5'd5;
        ex_mem_regwrite = 1'b1;
        tick();
        checks++;
        if (fwd_sel !== 4'b1000) begin
            errors++;
            $display("FAIL t2_youngest got=%b exp=1000", fwd_sel);
        end
        id_ex_rd = 5'd7;
        tick();
        checks++;
        if (fwd_sel !== 4'b0100) begin
            errors++;
            $display("FAIL t2_older got=%b exp=0100", fwd_sel);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_src_addr = {5'd0, 5'd4};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd4;
        id_ex_regwrite = 1'b1;
        id_ex_memread = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || start !== 1'b1) begin
            errors++;
            $display("FAIL t3_lu_stall got stall=%b bubble=%b start=%b exp 1 1 1", stall, bubble, start);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL t3_bubble_sel got=%b exp=0000", fwd_sel);
        end
        id_ex_regwrite = 1'b0;
        id_ex_memread = 1'b0;
        ex_mem_rd = 5'd4;
        ex_mem_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || start !== 1'b0 || cyc !== 16'd1) begin
            errors++;
            $display("FAIL t3_after got stall=%b start=%b cyc=%0d exp 0 0 1", stall, start, cyc);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            errors++;
            $display("FAIL t3_load_fwd got=%b exp=0001", fwd_sel);
        end
    endtask

    task automatic test_dep_stall();
        do_reset();
        forward_en = 1'b0;
        id_src_addr = {5'd0, 5'd6};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd6;
        id_ex_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || start !== 1'b1) begin
            errors++;
            $display("FAIL t4_ex_stall got stall=%b start=%b exp 1 1", stall, start);
        end
        tick();
        id_ex_regwrite = 1'b0;
        ex_mem_rd = 5'd6;
        ex_mem_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL t4_mem_stall got stall=%b start=%b exp 1 0", stall, start);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0000 || cyc !== 16'd2) begin
            errors++;
            $display("FAIL t4_mid got fwd_sel=%b cyc=%0d exp 0000 2", fwd_sel, cyc);
        end
        ex_mem_regwrite = 1'b0;
        mem_wb_rd = 5'd6;
        mem_wb_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL t4_wb_release got stall=%b start=%b exp 0 0", stall, start);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000 || cyc !== 16'd2) begin
            errors++;
            $display("FAIL t4_run got stall=%b fwd_sel=%b cyc=%0d exp 0 0000 2", stall, fwd_sel, cyc);
        end
    endtask

    task automatic test_zero_and_lu3();
        int n_stall;
        int n_start;
        do_reset();
        id_src_addr = '0;
        id_src_valid = 2'b11;
        id_ex_rd = 5'd0;
        id_ex_regwrite = 1'b1;
        id_ex_memread = 1'b1;
        ex_mem_rd = 5'd0;
        ex_mem_regwrite = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || stall_l3 !== 1'b0) begin
            errors++;
            $display("FAIL t5_r0_fwd got stall=%b stall_l3=%b exp 0 0", stall, stall_l3);
        end
        tick();
        forward_en = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL t5_r0_nofwd got stall=%b fwd_sel=%b exp 0 0000", stall, fwd_sel);
        end

        do_reset();
        id_src_addr = {5'd0, 5'd4};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd4;
        id_ex_regwrite = 1'b1;
        id_ex_memread = 1'b1;
        n_stall = 0;
        n_start = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_stall += int'(stall_l3);
            n_start += int'(start_l3);
            tick();
            if (k == 0) begin
                id_ex_regwrite = 1'b0;
                id_ex_memread = 1'b0;
                ex_mem_rd = 5'd4;
                ex_mem_regwrite = 1'b1;
            end
        end
        checks++;
        if (n_stall != 3 || n_start != 1 || cyc_l3 !== 16'd3) begin
            errors++;
            $display("FAIL t5_lu3 got stalls=%0d starts=%0d cyc=%0d exp 3 1 3", n_stall, n_start, cyc_l3);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        forward_en = 1'b0;
        id_src_addr = {5'd0, 5'd6};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd6;
        id_ex_regwrite = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_dep got stall=%b start=%b exp 1 0", stall, start);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || cyc !== 16'd0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL t6_async_rst got stall=%b bubble=%b cyc=%0d fwd_sel=%b exp 0 0 0 0000",
                     stall, bubble, cyc, fwd_sel);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || start !== 1'b1) begin
            errors++;
            $display("FAIL t6_restart got stall=%b start=%b exp 1 1", stall, start);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        forward_en = 1'b0;
        id_src_addr = {5'd0, 5'd9};
        id_src_valid = 2'b01;
        ex_mem_rd = 5'd9;
        ex_mem_regwrite = 1'b1;
        repeat (20) tick();
        checks++;
        if (cyc_c4 !== 4'hF || cyc !== 16'd20) begin
            errors++;
            $display("FAIL t6_saturate got cyc4=%0d cyc16=%0d exp 15 20", cyc_c4, cyc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        forward_en = 1'b0;
        id_src_addr = {5'd0, 5'd6};
        id_src_valid = 2'b01;
        id_ex_rd = 5'd6;
        id_ex_regwrite = 1'b1;
        tick();
        forward_en = 1'b1;
        id_ex_memread = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release got stall=%b start=%b exp 0 0", stall, start);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || start !== 1'b1) begin
            errors++;
            $display("FAIL b2b_new_episode got stall=%b start=%b exp 1 1", stall, start);
        end
        tick();
        checks++;
        if (cyc !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=2", cyc);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fwd_exmem();
        test_priority();
        test_load_use();
        test_dep_stall();
        test_zero_and_lu3();
        test_reset_mid_stall();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
